hht_mem_responder: RTL and testbench
====================================

Name: hht_mem_responder

Overview:
- Memory-side responder for the HHT control block; serves the control block's two read ports and its base-register lookups.
- Read port 1 (addr1→dataIn1) serves column/vector words.
- Read port 2 (addr2→dataIn2) serves value words.
- Base ports return base addresses for regaddr1/regaddr2.
- Single-port CPU write path preloads the memory and the base registers; a mem_init sweep clears the whole memory.

Parameters:
- DEPTH, 512, number of 32-bit words in the data store.
- BASE_ADDR, 0, byte-free word address mapped to store index 0.
- DEFAULT_DATA, 99999, value returned for out-of-range or blocked reads.
- NREG, 32, number of base registers (index width fixed at 5).

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous reset, active-high
- RD  in  1  read enable, applies to both read ports
- addr1  in  32  read address, port 1
- addr2  in  32  read address, port 2
- dataIn1  out  32  read data, port 1
- dataIn2  out  32  read data, port 2
- valid1  out  1  dataIn1 holds a response this cycle
- valid2  out  1  dataIn2 holds a response this cycle
- err1  out  1  port-1 address out of range
- err2  out  1  port-2 address out of range
- regaddr1  in  5  base register index A
- regaddr2  in  5  base register index B
- base_dat_a  out  32  contents of regaddr1
- base_dat_b  out  32  contents of regaddr2
- WR  in  1  CPU write strobe
- cpu_addr  in  32  CPU write word address
- cpu_wdata  in  32  CPU write data
- reg_wr  in  1  base-register write strobe
- reg_waddr  in  5  base-register write index
- reg_wdata  in  32  base-register write data
- mem_init  in  1  start clear sweep (level, sampled when IDLE)
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (Rst=1 at edge):
  - dataIn1/2 = DEFAULT_DATA; valid1/2 = 0; err1/2 = 0; busy = 0.
  - All base registers = 0; base_dat_a/b = 0; FSM = IDLE.
  - Data store contents are NOT altered by reset.
- In range means BASE_ADDR ≤ addr < BASE_ADDR+DEPTH; index = addr−BASE_ADDR.
- Read, latency 1:
  - If RD=1 in cycle N while IDLE, then in cycle N+1 valid=1.
  - Data = store[index] if in range, else DEFAULT_DATA with err=1.
  - If RD=0, valid=0 next cycle; dataIn holds its last value.
- Ports are independent. The same address on both ports returns the same word on both.
- CPU write (WR=1, IDLE, in range): store[index] ← cpu_wdata at the edge.
  - Out-of-range write is dropped silently.
- Read and write to the same index in the same cycle: read-before-write. The response carries the old word; the new word is visible from the next read.
- Base registers:
  - base_dat_a/b are registered: value of reg[regaddr1/2] one cycle after the index is presented.
  - A reg_wr to the index being read in the same cycle forwards reg_wdata (write-through).
  - reg_wr is accepted in all FSM states.
- FSM:
  - IDLE: if mem_init=1, go to CLEAR with clr_idx=0 and busy=1.
  - CLEAR: each cycle store[clr_idx] ← 0 and clr_idx increments.
  - At clr_idx=DEPTH−1, write it, then return to IDLE with busy=0 on the next cycle. A full sweep takes exactly DEPTH cycles of busy=1.
  - During CLEAR, RD and WR are ignored: valid=0, no store writes, no err.
  - mem_init held high during CLEAR does not restart the sweep. Held high on return to IDLE, it starts a new sweep.
- Reset during CLEAR: FSM returns to IDLE and busy=0. A partially cleared store is left as-is.
- Address arithmetic is 32-bit unsigned; index is truncated to clog2(DEPTH) bits only after the range check. No wrap-around aliasing.

Test Plan:
- Reset/defaults: Rst=1 for 2 cycles → dataIn1=dataIn2=99999, valid=0, busy=0, base_dat_a=0.
- Preload and dual read:
  - Preload store[180]=13 and store[2]=25 via WR (BASE_ADDR=0, DEPTH=512).
  - Then RD=1, addr1=180, addr2=2 → next cycle dataIn1=13, dataIn2=25, valid1=valid2=1.
- Range error: RD=1, addr1=600 → next cycle dataIn1=99999, err1=1, valid1=1. Port 2 is unaffected.
- Same-cycle hazard:
  - store[181]=10; WR cpu_addr=181 cpu_wdata=77 while RD addr1=181 → response 10.
  - Next read of 181 → 77.
- Base registers:
  - reg_wr reg_waddr=6 reg_wdata=180 while regaddr1=6 → base_dat_a=180 next cycle (forwarded).
  - regaddr2=9 after writing 2 there → base_dat_b=2.
- Clear sweep:
  - Pulse mem_init → busy high exactly 512 cycles. A RD during the sweep gives valid=0.
  - Afterwards, reading 180 → 0.
  - Rst asserted at sweep cycle 100 → busy=0 next cycle, and store[300] keeps its prior value.

Source files
------------

// File: rtl/hht_mem_responder.sv
// Memory-side responder for the HHT control block: two latency-1 read ports,
// registered base-register lookups, a CPU preload path and a clear sweep.
module hht_mem_responder #(
  parameter int DEPTH        = 512,
  parameter int BASE_ADDR    = 0,
  parameter int DEFAULT_DATA = 99999,
  parameter int NREG         = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RD,
  input  logic [31:0] addr1,
  input  logic [31:0] addr2,
  output logic [31:0] dataIn1,
  output logic [31:0] dataIn2,
  output logic        valid1,
  output logic        valid2,
  output logic        err1,
  output logic        err2,
  input  logic [4:0]  regaddr1,
  input  logic [4:0]  regaddr2,
  output logic [31:0] base_dat_a,
  output logic [31:0] base_dat_b,
  input  logic        WR,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        reg_wr,
  input  logic [4:0]  reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        mem_init,
  output logic        busy
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [31:0] DEF_W   = 32'(DEFAULT_DATA);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic          busy_q;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] regs_q [NREG];

  logic [31:0] data1_q, data2_q, base_a_q, base_b_q;
  logic        valid1_q, valid2_q, err1_q, err2_q;

  logic [31:0] off1_s, off2_s, offc_s;
  logic        in1_s, in2_s, inc_s, idle_s;
  logic [31:0] rd_a_s, rd_b_s;

  // Subtract first, then compare: avoids overflow of BASE_ADDR+DEPTH.
  always_comb begin
    off1_s = addr1 - BASE_W;
    off2_s = addr2 - BASE_W;
    offc_s = cpu_addr - BASE_W;
    in1_s  = (addr1 >= BASE_W) && (off1_s < DEPTH_W);
    in2_s  = (addr2 >= BASE_W) && (off2_s < DEPTH_W);
    inc_s  = (cpu_addr >= BASE_W) && (offc_s < DEPTH_W);
    idle_s = (state_q == IDLE);
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (mem_init) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + IW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= (state_d == CLEAR);
    end
  end

  // Store is never reset; reads below see the pre-edge contents (read-before-write).
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state_q == CLEAR) begin
        mem_q[clr_idx_q] <= 32'd0;
      end else if (WR && inc_s) begin
        mem_q[offc_s[IW-1:0]] <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      data1_q  <= DEF_W;
      data2_q  <= DEF_W;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      err1_q   <= 1'b0;
      err2_q   <= 1'b0;
    end else begin
      valid1_q <= RD && idle_s;
      valid2_q <= RD && idle_s;
      err1_q   <= RD && idle_s && !in1_s;
      err2_q   <= RD && idle_s && !in2_s;
      if (RD && idle_s) begin
        data1_q <= in1_s ? mem_q[off1_s[IW-1:0]] : DEF_W;
        data2_q <= in2_s ? mem_q[off2_s[IW-1:0]] : DEF_W;
      end
    end
  end

  // Write-through: a same-cycle write to the looked-up index is forwarded.
  always_comb begin
    rd_a_s = (32'(regaddr1) < 32'(NREG)) ? regs_q[regaddr1] : 32'd0;
    rd_b_s = (32'(regaddr2) < 32'(NREG)) ? regs_q[regaddr2] : 32'd0;
    if (reg_wr && (reg_waddr == regaddr1)) begin
      rd_a_s = reg_wdata;
    end else begin
      rd_a_s = rd_a_s;
    end
    if (reg_wr && (reg_waddr == regaddr2)) begin
      rd_b_s = reg_wdata;
    end else begin
      rd_b_s = rd_b_s;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 32'd0;
      end
      base_a_q <= 32'd0;
      base_b_q <= 32'd0;
    end else begin
      if (reg_wr && (32'(reg_waddr) < 32'(NREG))) begin
        regs_q[reg_waddr] <= reg_wdata;
      end
      base_a_q <= rd_a_s;
      base_b_q <= rd_b_s;
    end
  end

  assign dataIn1    = data1_q;
  assign dataIn2    = data2_q;
  assign valid1     = valid1_q;
  assign valid2     = valid2_q;
  assign err1       = err1_q;
  assign err2       = err2_q;
  assign base_dat_a = base_a_q;
  assign base_dat_b = base_b_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hht_mem_responder.sv
// Directed self-checking bench for hht_mem_responder (DEPTH=512, BASE_ADDR=0).
module tb_hht_mem_responder;

  logic        Clk = 1'b0;
  logic        Rst, RD, WR, reg_wr, mem_init;
  logic [31:0] addr1, addr2, cpu_addr, cpu_wdata, reg_wdata;
  logic [4:0]  regaddr1, regaddr2, reg_waddr;
  logic [31:0] dataIn1, dataIn2, base_dat_a, base_dat_b;
  logic        valid1, valid2, err1, err2, busy;

  int checks = 0;
  int errors = 0;
  int cnt;

  hht_mem_responder dut (
    .Clk(Clk), .Rst(Rst), .RD(RD), .addr1(addr1), .addr2(addr2),
    .dataIn1(dataIn1), .dataIn2(dataIn2), .valid1(valid1), .valid2(valid2),
    .err1(err1), .err2(err2), .regaddr1(regaddr1), .regaddr2(regaddr2),
    .base_dat_a(base_dat_a), .base_dat_b(base_dat_b), .WR(WR),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .reg_wr(reg_wr),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .mem_init(mem_init),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    WR = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    WR = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; RD = 1'b0; WR = 1'b0; reg_wr = 1'b0; mem_init = 1'b0;
    addr1 = 32'd0; addr2 = 32'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    reg_wdata = 32'd0; regaddr1 = 5'd0; regaddr2 = 5'd0; reg_waddr = 5'd0;
    tick(); tick();
    Rst = 1'b0;
    chk("rst_data1", dataIn1, 32'd99999);
    chk("rst_data2", dataIn2, 32'd99999);
    chk("rst_valid1", {31'd0, valid1}, 32'd0);
    chk("rst_valid2", {31'd0, valid2}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_base_a", base_dat_a, 32'd0);

    cpu_write(32'd180, 32'd13);
    cpu_write(32'd2, 32'd25);
    cpu_write(32'd181, 32'd10);
    cpu_write(32'd511, 32'd7);
    cpu_write(32'd512, 32'd44);

    RD = 1'b1; addr1 = 32'd180; addr2 = 32'd2;
    tick();
    chk("dual_d1", dataIn1, 32'd13);
    chk("dual_d2", dataIn2, 32'd25);
    chk("dual_v1", {31'd0, valid1}, 32'd1);
    chk("dual_v2", {31'd0, valid2}, 32'd1);
    chk("dual_e1", {31'd0, err1}, 32'd0);

    addr1 = 32'd600;
    tick();
    chk("oor_d1", dataIn1, 32'd99999);
    chk("oor_e1", {31'd0, err1}, 32'd1);
    chk("oor_v1", {31'd0, valid1}, 32'd1);
    chk("oor_d2", dataIn2, 32'd25);
    chk("oor_e2", {31'd0, err2}, 32'd0);

    addr1 = 32'd511; addr2 = 32'd512;
    tick();
    chk("edge_last", dataIn1, 32'd7);
    chk("edge_last_err", {31'd0, err1}, 32'd0);
    chk("edge_past", dataIn2, 32'd99999);
    chk("edge_past_err", {31'd0, err2}, 32'd1);

    addr1 = 32'hFFFF_FFFF; addr2 = 32'd180;
    tick();
    chk("max_addr", dataIn1, 32'd99999);
    chk("same_word_a", dataIn2, 32'd13);

    RD = 1'b0;
    tick();
    chk("idle_v1", {31'd0, valid1}, 32'd0);
    chk("idle_hold", dataIn2, 32'd13);
    chk("idle_e1", {31'd0, err1}, 32'd0);

    RD = 1'b1; addr1 = 32'd181; WR = 1'b1; cpu_addr = 32'd181; cpu_wdata = 32'd77;
    tick();
    WR = 1'b0;
    chk("haz_old", dataIn1, 32'd10);
    tick();
    chk("haz_new", dataIn1, 32'd77);
    RD = 1'b0;

    reg_wr = 1'b1; reg_waddr = 5'd6; reg_wdata = 32'd180; regaddr1 = 5'd6;
    tick();
    chk("base_fwd", base_dat_a, 32'd180);
    reg_waddr = 5'd9; reg_wdata = 32'd2;
    tick();
    reg_wr = 1'b0; regaddr2 = 5'd9;
    tick();
    chk("base_b", base_dat_b, 32'd2);
    chk("base_a_hold", base_dat_a, 32'd180);

    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    cnt = 0;
    while (busy && cnt < 2000) begin
      if (cnt == 10) begin
        RD = 1'b1; addr1 = 32'd180;
      end else if (cnt == 11) begin
        chk("sweep_v1", {31'd0, valid1}, 32'd0);
        chk("sweep_e1", {31'd0, err1}, 32'd0);
        RD = 1'b0;
      end
      cnt++;
      tick();
    end
    chk("sweep_len", cnt, 32'd512);
    RD = 1'b1; addr1 = 32'd180;
    tick();
    RD = 1'b0;
    chk("cleared", dataIn1, 32'd0);

    cpu_write(32'd300, 32'd55);
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    chk("sweep2_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 100; i++) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_data", dataIn1, 32'd99999);
    chk("rst_mid_base", base_dat_a, 32'd0);
    tick();
    chk("rst_mid_idle", {31'd0, busy}, 32'd0);
    RD = 1'b1; addr1 = 32'd300; addr2 = 32'd50;
    tick();
    RD = 1'b0;
    chk("kept_300", dataIn1, 32'd55);
    chk("cleared_50", dataIn2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
